// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and scheduler state type for the UART TX path
package uart_pkg;
  localparam int UART_DATA_W = 9;
  localparam int UART_FRAME_CYCLES = 14;
  typedef enum logic [1:0] {IDLE, SEND, GAP} sched_state_t;
endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick starting one past the last grant
//   req   in  NUM_REQ           pending requests
//   last  in  $clog2(NUM_REQ)   index granted most recently
//   grant out NUM_REQ           one-hot winner (zero when nothing is pending)
//   idx   out $clog2(NUM_REQ)   winner index
//   any   out 1                 some request is pending
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);
  int j;
  // Scan farthest offset first so the nearest valid index after last wins.
  always_comb begin
    j = 0;
    idx = '0;
    any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(last) + k) % NUM_REQ;
      if (req[j[IW-1:0]]) begin
        idx = j[IW-1:0];
        any = 1'b1;
      end
    end
    grant = any ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter, frames timed by cycle count
//   txclk, reset             clock and synchronous active-high reset
//   req_valid/req_data       per-requester pending flag and packed word
//   req_ready                one-hot accept, only in IDLE
//   tx_enable/tx_data        transmitter drive, data held for the whole frame
//   busy, grant_id, frame_done status
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = UART_DATA_W,
  parameter int FRAME_CYCLES = UART_FRAME_CYCLES,
  parameter int GAP_CYCLES = 2,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2((FRAME_CYCLES > GAP_CYCLES ? FRAME_CYCLES : GAP_CYCLES) + 1)
) (
  input  logic                      txclk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_enable,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      busy,
  output logic [IW-1:0]             grant_id,
  output logic                      frame_done
);
  if (GAP_CYCLES < 1 || NUM_REQ < 2) begin : g_bad_cfg
    $error("uart_tx_scheduler: GAP_CYCLES must be >=1 and NUM_REQ >=2");
  end
  sched_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IW-1:0] gid_q, gid_d, last_q, last_d, win_idx;
  logic done_q, done_d, win_any;
  logic [NUM_REQ-1:0] win_grant;
  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req_valid),
    .last(last_q),
    .grant(win_grant),
    .idx(win_idx),
    .any(win_any)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    data_d = data_q;
    gid_d = gid_q;
    last_d = last_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: if (win_any) begin
        data_d = req_data[win_idx*DATA_W +: DATA_W];
        gid_d = win_idx;
        last_d = win_idx;
        cnt_d = '0;
        state_d = SEND;
      end
      SEND: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(FRAME_CYCLES - 1)) begin
          state_d = GAP;
          cnt_d = '0;
          done_d = 1'b1;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge txclk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      data_q <= '0;
      gid_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      gid_q <= gid_d;
      last_q <= last_d;
      done_q <= done_d;
    end
  end
  assign req_ready = (state_q == IDLE && !reset) ? win_grant : '0;
  assign tx_enable = state_q == SEND;
  assign busy = state_q != IDLE;
  assign tx_data = data_q;
  assign grant_id = gid_q;
  assign frame_done = done_q;
endmodule
